// File: rtl/gpu_cmd_issuer.sv
// Purpose : queue CPU clear/draw requests and issue them one at a time on the gpu_* bus.
// Latency : request accepted at edge N on an empty queue with an idle gpu -> submit pulse from edge N+1.
// Backpr. : req_ready = !fifo_full (registered count); one command in flight, gated by gpu_ready.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   req_valid/req_ready  request handshake from the core
//   req_cmd/offset/x/y/length  request fields (DRAW fields are masked on accept)
//   gpu_cmd, gpu_draw_*  registered command bus, loaded on submit, held while in flight
//   gpu_cmd_submitted    1-cycle submit pulse
//   gpu_ready            gpu idle / accepting
//   cmd_done             1-cycle pulse per retired command
//   idle                 queue empty and no command in flight
//   err_timeout          sticky: a submit was never accepted by the gpu

// Generic synchronous FIFO with registered occupancy count.
// Latency: pushed entry visible at head the cycle after the push edge.
// Backpressure: caller must not push while full or pop while empty.
module gpu_cmd_fifo #(
   parameter int WIDTH = 44,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] head_dat,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // Storage needs no reset: count gates every read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_dat;
   end

   assign head_dat = mem[rd_ptr];
   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
endmodule

module gpu_cmd_issuer #(
   parameter int FIFO_DEPTH     = 4,
   parameter int ACCEPT_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_cmd,
   input  logic [15:0] req_offset,
   input  logic [7:0]  req_x,
   input  logic [7:0]  req_y,
   input  logic [7:0]  req_length,
   output logic [3:0]  gpu_cmd,
   output logic [15:0] gpu_draw_offset,
   output logic [7:0]  gpu_draw_x,
   output logic [7:0]  gpu_draw_y,
   output logic [7:0]  gpu_draw_length,
   output logic        gpu_cmd_submitted,
   input  logic        gpu_ready,
   output logic        cmd_done,
   output logic        idle,
   output logic        err_timeout
);
   localparam logic [3:0] CMD_DRAW = 4'h2;
   localparam int         CW       = $clog2(ACCEPT_TIMEOUT);

   typedef struct packed {
      logic [3:0]  cmd;
      logic [15:0] offset;
      logic [7:0]  x;
      logic [7:0]  y;
      logic [7:0]  length;
   } entry_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_ACCEPT,
      S_WAIT_DONE
   } state_t;

   state_t  state;
   state_t  next_state;
   entry_t  in_entry;
   entry_t  head;
   logic    fifo_full;
   logic    fifo_empty;
   logic    accept;
   logic    push;
   logic    load;
   logic    cnt_inc;
   logic    set_timeout;
   logic    set_done;
   logic [CW-1:0] cnt;

   // ---------------- enqueue path ----------------
   assign req_ready = !fifo_full;
   assign accept    = req_valid && req_ready;

   // DRAW start coordinates wrap to the 64x32 screen; rows limited to 15.
   always_comb begin
      in_entry.cmd    = req_cmd;
      in_entry.offset = req_offset;
      in_entry.x      = req_x;
      in_entry.y      = req_y;
      in_entry.length = req_length;
      if (req_cmd == CMD_DRAW) begin
         in_entry.x      = req_x & 8'h3F;
         in_entry.y      = req_y & 8'h1F;
         in_entry.length = req_length & 8'h0F;
      end
   end

   // A zero-row draw is a no-op: handshake completes but nothing is queued.
   assign push = accept && !((req_cmd == CMD_DRAW) && (in_entry.length == 8'h00));

   gpu_cmd_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_dat (in_entry),
      .pop      (load),
      .head_dat (head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // ---------------- issue FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state  = state;
      load        = 1'b0;
      cnt_inc     = 1'b0;
      set_timeout = 1'b0;
      set_done    = 1'b0;
      case (state)
         S_IDLE: begin
            if (!fifo_empty && gpu_ready) begin
               load       = 1'b1;
               next_state = S_WAIT_ACCEPT;
            end
         end
         S_WAIT_ACCEPT: begin
            // gpu_ready is still high on the first edge here; that only counts.
            if (!gpu_ready) begin
               next_state = S_WAIT_DONE;
            end else if (cnt == CW'(ACCEPT_TIMEOUT - 1)) begin
               set_timeout = 1'b1;
               next_state  = S_IDLE;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         S_WAIT_DONE: begin
            if (gpu_ready) begin
               set_done   = 1'b1;
               next_state = S_IDLE;
            end
         end
         default: next_state = S_IDLE;
      endcase
   end

   // ---------------- registered outputs ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gpu_cmd           <= '0;
         gpu_draw_offset   <= '0;
         gpu_draw_x        <= '0;
         gpu_draw_y        <= '0;
         gpu_draw_length   <= '0;
         gpu_cmd_submitted <= 1'b0;
         cmd_done          <= 1'b0;
         err_timeout       <= 1'b0;
         cnt               <= '0;
      end else begin
         // Bus only changes on a load, so it is stable for the whole flight.
         if (load) begin
            gpu_cmd         <= head.cmd;
            gpu_draw_offset <= head.offset;
            gpu_draw_x      <= head.x;
            gpu_draw_y      <= head.y;
            gpu_draw_length <= head.length;
         end
         gpu_cmd_submitted <= load;
         cmd_done          <= set_done;
         if (set_timeout) err_timeout <= 1'b1;
         if (load)         cnt <= '0;
         else if (cnt_inc) cnt <= cnt + 1'b1;
      end
   end

   assign idle = fifo_empty && (state == S_IDLE);
endmodule
